// File: rtl/dm_sysbus_access_pkg.sv
// Shared debug-module types used by the system-bus access engine:
// sberror codes and the SBA state machine encoding.
package dm_sysbus_access_pkg;

  typedef enum logic [2:0] {
    SBE_NONE      = 3'd0,
    SBE_TIMEOUT   = 3'd1,
    SBE_BADADDR   = 3'd2,
    SBE_ALIGNMENT = 3'd3,
    SBE_SIZE      = 3'd4,
    SBE_OTHER     = 3'd7
  } sberror_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ       = 3'd1,
    S_WRITE      = 3'd2,
    S_WAIT_READ  = 3'd3,
    S_WAIT_WRITE = 3'd4
  } sba_state_e;

endpackage

// File: rtl/dm_sysbus_access.sv
// System-bus access engine: turns debugger sbaddress/sbdata strobes into
// single req/gnt/r_valid bus transfers and reports data, address and errors.
module dm_sysbus_access
  import dm_sysbus_access_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int MaxSize = (BusWidth == 64) ? 3 : 2;
  localparam int BeW     = BusWidth / 8;

  // Low address bits that must be zero for an access of 2**size bytes.
  function automatic logic [MaxSize-1:0] low_mask(input logic [2:0] size);
    logic [MaxSize-1:0] m;
    for (int i = 0; i < MaxSize; i++) m[i] = (i < int'(size));
    return m;
  endfunction

  function automatic logic [BeW-1:0] byte_mask(input logic [2:0] size);
    logic [BeW-1:0] m;
    int n;
    n = 32'd1 << size;
    for (int i = 0; i < BeW; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [BusWidth-1:0] expand_mask(input logic [BeW-1:0] bm);
    logic [BusWidth-1:0] m;
    for (int i = 0; i < BeW; i++) m[8*i +: 8] = {8{bm[i]}};
    return m;
  endfunction

  sba_state_e           state_r, state_next_s;
  sberror_e             sberror_s;
  logic [MaxSize-1:0]   offset_s;
  logic [MaxSize+2:0]   shift_s;
  logic [BeW-1:0]       size_be_s;
  logic [BusWidth-1:0]  incr_s;
  logic                 start_rd_s, start_any_s, go_write_s, misaligned_s;

  assign offset_s     = sbaddress_i[MaxSize-1:0];
  assign shift_s      = {offset_s, 3'b000};
  assign size_be_s    = byte_mask(sbaccess_i);
  assign incr_s       = {{(BusWidth-1){1'b0}}, 1'b1} << sbaccess_i;
  assign misaligned_s = (offset_s & low_mask(sbaccess_i)) != {MaxSize{1'b0}};

  // Read-on-data outranks a data write, which outranks read-on-address.
  assign start_rd_s  = sbdata_read_valid_i & sbreadondata_i;
  assign go_write_s  = ~start_rd_s & sbdata_write_valid_i;
  assign start_any_s = start_rd_s | sbdata_write_valid_i
                     | (sbaddress_write_valid_i & sbreadonaddr_i);

  assign master_add_o   = sbaddress_i;
  assign master_be_o    = size_be_s << offset_s;
  assign master_wdata_o = sbdata_i << shift_s;
  assign sbdata_o       = (master_r_rdata_i >> shift_s) & expand_mask(size_be_s);
  assign master_req_o   = (state_r == S_READ) || (state_r == S_WRITE);
  assign master_we_o    = (state_r == S_WRITE);
  assign sbbusy_o       = (state_r != S_IDLE);
  assign sberror_o      = sberror_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, completion strobes, error strobe and post-increment address.
  always_comb begin
    state_next_s    = state_r;
    sbdata_valid_o  = 1'b0;
    sberror_valid_o = 1'b0;
    sberror_s       = SBE_NONE;
    sbaddress_o     = sbaddress_i;
    if (dmactive_i) begin
      case (state_r)
        S_IDLE: begin
          if (start_any_s) begin
            if (sbaccess_i > 3'(MaxSize)) begin
              sberror_valid_o = 1'b1;
              sberror_s       = SBE_SIZE;
            end else if (misaligned_s) begin
              sberror_valid_o = 1'b1;
              sberror_s       = SBE_ALIGNMENT;
            end else if (go_write_s) begin
              state_next_s = S_WRITE;
            end else begin
              state_next_s = S_READ;
            end
          end else begin
            state_next_s = S_IDLE;
          end
        end
        // A response seen together with the grant belongs to the wait state.
        S_READ: begin
          if (master_gnt_i) state_next_s = S_WAIT_READ;
          else state_next_s = S_READ;
        end
        S_WRITE: begin
          if (master_gnt_i) state_next_s = S_WAIT_WRITE;
          else state_next_s = S_WRITE;
        end
        S_WAIT_READ, S_WAIT_WRITE: begin
          if (master_r_valid_i) begin
            state_next_s   = S_IDLE;
            sbdata_valid_o = (state_r == S_WAIT_READ);
            if (sbautoincrement_i) sbaddress_o = sbaddress_i + incr_s;
            else sbaddress_o = sbaddress_i;
          end else begin
            state_next_s = state_r;
          end
        end
        default: state_next_s = S_IDLE;
      endcase
    end else begin
      state_next_s = S_IDLE;
    end
  end

endmodule

// File: tb/tb_dm_sysbus_access.sv
// Directed bench for dm_sysbus_access: a vector table for start decode and
// lane steering in Idle, then hand-written multi-cycle transfer sequences.
module tb_dm_sysbus_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmactive;
  logic        req, we, gnt, r_valid;
  logic [31:0] add, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] sbaddr_in, sbaddr_out, sbdata_in, sbdata_out;
  logic        sbaddr_wv, roa, rod, autoinc, sbdata_wv, sbdata_rv;
  logic [2:0]  access;
  logic        dvalid, busy, evalid;
  logic [2:0]  err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_sysbus_access #(.BusWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .master_req_o(req), .master_add_o(add), .master_we_o(we),
    .master_wdata_o(wdata), .master_be_o(be), .master_gnt_i(gnt),
    .master_r_valid_i(r_valid), .master_r_rdata_i(rdata),
    .sbaddress_i(sbaddr_in), .sbaddress_o(sbaddr_out),
    .sbaddress_write_valid_i(sbaddr_wv), .sbreadonaddr_i(roa),
    .sbreadondata_i(rod), .sbautoincrement_i(autoinc), .sbaccess_i(access),
    .sbdata_i(sbdata_in), .sbdata_write_valid_i(sbdata_wv),
    .sbdata_read_valid_i(sbdata_rv), .sbdata_o(sbdata_out),
    .sbdata_valid_o(dvalid), .sbbusy_o(busy), .sberror_valid_o(evalid),
    .sberror_o(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_strobes();
    sbaddr_wv = 1'b0;
    sbdata_wv = 1'b0;
    sbdata_rv = 1'b0;
  endtask

  // strb: 0 none, 1 sbaddress write, 2 sbdata write, 3 sbdata read
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  acc;
    logic [31:0] wd_in;
    logic [31:0] rd_in;
    logic [1:0]  strb;
    logic        ainc;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_sbdata;
    logic        exp_evalid;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h0000_1003, 3'd0, 32'h0000_005A, 32'h1122_3344, 2'd0, 1'b0, 4'b1000, 32'h5A00_0000, 32'h0000_0011, 1'b0, 3'd0};
    vecs[1] = '{32'h0000_1002, 3'd1, 32'h0000_BEEF, 32'hCAFE_F00D, 2'd0, 1'b0, 4'b1100, 32'hBEEF_0000, 32'h0000_CAFE, 1'b0, 3'd0};
    vecs[2] = '{32'h0000_1000, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 2'd0, 1'b1, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 3'd0};
    vecs[3] = '{32'h0000_1001, 3'd0, 32'h0000_00A5, 32'h0000_C300, 2'd0, 1'b0, 4'b0010, 32'h0000_A500, 32'h0000_00C3, 1'b0, 3'd0};
    vecs[4] = '{32'h0000_1001, 3'd1, 32'h0000_0000, 32'h00AB_CD00, 2'd1, 1'b0, 4'b0110, 32'h0000_0000, 32'h0000_ABCD, 1'b1, 3'd3};
    vecs[5] = '{32'h0000_1000, 3'd3, 32'h0000_0000, 32'h0000_0000, 2'd3, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'd4};
    vecs[6] = '{32'h0000_1002, 3'd2, 32'h1122_3344, 32'h0000_0000, 2'd2, 1'b0, 4'b1100, 32'h3344_0000, 32'h0000_0000, 1'b1, 3'd3};
    vecs[7] = '{32'h0000_1004, 3'd7, 32'h0000_0000, 32'h0000_0000, 2'd2, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'd4};
    vecs[8] = '{32'h0000_1003, 3'd3, 32'h0000_0000, 32'hAABB_CCDD, 2'd1, 1'b0, 4'b1000, 32'h0000_0000, 32'h0000_00AA, 1'b1, 3'd4};

    rst_n = 1'b0; dmactive = 1'b1; gnt = 1'b0; r_valid = 1'b0;
    rdata = 32'hABCD_1234; sbaddr_in = 32'h0000_1002; sbdata_in = 32'h0;
    roa = 1'b0; rod = 1'b0; autoinc = 1'b0; access = 3'd1;
    clear_strobes();

    // Reset state and combinational outputs during reset
    #2;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check("rst_evalid", {31'd0, evalid}, 32'd0);
    check("rst_err", {29'd0, err}, 32'd0);
    check("rst_add", add, 32'h0000_1002);
    check("rst_sbaddr_o", sbaddr_out, 32'h0000_1002);
    check("rst_sbdata_o", sbdata_out, 32'h0000_ABCD);
    @(negedge clk); rst_n = 1'b1;

    // Vector table: decode and error checks in Idle
    roa = 1'b1; rod = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sbaddr_in = vecs[i].addr; access = vecs[i].acc; sbdata_in = vecs[i].wd_in;
      rdata = vecs[i].rd_in; autoinc = vecs[i].ainc;
      sbaddr_wv = (vecs[i].strb == 2'd1);
      sbdata_wv = (vecs[i].strb == 2'd2);
      sbdata_rv = (vecs[i].strb == 2'd3);
      #1;
      check($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, vecs[i].exp_be});
      check($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_sbdata", i), sbdata_out, vecs[i].exp_sbdata);
      check($sformatf("v%0d_add", i), add, vecs[i].addr);
      check($sformatf("v%0d_sbaddr_o", i), sbaddr_out, vecs[i].addr);
      check($sformatf("v%0d_evalid", i), {31'd0, evalid}, {31'd0, vecs[i].exp_evalid});
      check($sformatf("v%0d_err", i), {29'd0, err}, {29'd0, vecs[i].exp_err});
      @(negedge clk);
      clear_strobes();
      #1;
      check($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_req_after", i), {31'd0, req}, 32'd0);
    end
    roa = 1'b0; rod = 1'b0; autoinc = 1'b0;

    // Word read on address write, grant on first req cycle, response two cycles later
    @(negedge clk);
    sbaddr_in = 32'h0000_1000; access = 3'd2; roa = 1'b1; sbaddr_wv = 1'b1;
    #1 check("rd_busy_start", {31'd0, busy}, 32'd0);
    @(negedge clk);
    clear_strobes(); gnt = 1'b1;
    #1;
    check("rd_req", {31'd0, req}, 32'd1);
    check("rd_we", {31'd0, we}, 32'd0);
    check("rd_busy1", {31'd0, busy}, 32'd1);
    check("rd_add", add, 32'h0000_1000);
    check("rd_be", {28'd0, be}, 32'h0000_000F);
    @(negedge clk);
    gnt = 1'b0;
    #1;
    check("rd_req_wait", {31'd0, req}, 32'd0);
    check("rd_busy2", {31'd0, busy}, 32'd1);
    check("rd_dvalid_early", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    r_valid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    check("rd_busy3", {31'd0, busy}, 32'd1);
    check("rd_dvalid", {31'd0, dvalid}, 32'd1);
    check("rd_sbdata", sbdata_out, 32'hDEAD_BEEF);
    check("rd_sbaddr_noinc", sbaddr_out, 32'h0000_1000);
    @(negedge clk);
    r_valid = 1'b0; roa = 1'b0;
    #1;
    check("rd_busy_end", {31'd0, busy}, 32'd0);
    check("rd_dvalid_end", {31'd0, dvalid}, 32'd0);

    // Byte write with autoincrement, grant withheld for 5 cycles
    @(negedge clk);
    sbaddr_in = 32'h0000_1003; access = 3'd0; sbdata_in = 32'h0000_005A;
    autoinc = 1'b1; sbdata_wv = 1'b1;
    @(negedge clk);
    clear_strobes();
    for (int c = 0; c < 6; c++) begin
      gnt = (c == 5);
      #1;
      check($sformatf("wr_req_c%0d", c), {31'd0, req}, 32'd1);
      check($sformatf("wr_we_c%0d", c), {31'd0, we}, 32'd1);
      check($sformatf("wr_add_c%0d", c), add, 32'h0000_1003);
      check($sformatf("wr_be_c%0d", c), {28'd0, be}, 32'h0000_0008);
      check($sformatf("wr_wdata_c%0d", c), wdata, 32'h5A00_0000);
      @(negedge clk);
    end
    gnt = 1'b0; r_valid = 1'b1;
    #1;
    check("wr_req_wait", {31'd0, req}, 32'd0);
    check("wr_sbaddr_inc", sbaddr_out, 32'h0000_1004);
    check("wr_dvalid", {31'd0, dvalid}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    r_valid = 1'b0;
    #1;
    check("wr_busy_end", {31'd0, busy}, 32'd0);
    check("wr_sbaddr_idle", sbaddr_out, 32'h0000_1003);

    // Grant and r_valid together in Read: the response is not taken
    @(negedge clk);
    sbaddr_in = 32'h0000_2000; access = 3'd2; autoinc = 1'b0;
    rod = 1'b1; sbdata_rv = 1'b1;
    @(negedge clk);
    clear_strobes(); gnt = 1'b1; r_valid = 1'b1; rdata = 32'h1111_2222;
    #1 check("gr_same_dvalid", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    gnt = 1'b0; r_valid = 1'b0;
    #1 check("gr_same_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    r_valid = 1'b1; rdata = 32'h0BAD_F00D;
    #1;
    check("gr_same_dvalid2", {31'd0, dvalid}, 32'd1);
    check("gr_same_sbdata", sbdata_out, 32'h0BAD_F00D);
    @(negedge clk);
    r_valid = 1'b0; rod = 1'b0;

    // dmactive drop in WaitRead, then a late response is ignored
    @(negedge clk);
    sbaddr_in = 32'h0000_3000; roa = 1'b1; sbaddr_wv = 1'b1;
    @(negedge clk);
    clear_strobes(); gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; dmactive = 1'b0;
    #1 check("dm_busy_wait", {31'd0, busy}, 32'd1);
    @(negedge clk);
    dmactive = 1'b1; r_valid = 1'b1;
    #1;
    check("dm_busy_after", {31'd0, busy}, 32'd0);
    check("dm_late_dvalid", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    r_valid = 1'b0; roa = 1'b0;

    // Autoincrement wraps at the top of the address space
    @(negedge clk);
    sbaddr_in = 32'hFFFF_FFFC; access = 3'd2; autoinc = 1'b1; sbdata_wv = 1'b1;
    @(negedge clk);
    clear_strobes(); gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; r_valid = 1'b1;
    #1 check("wrap_sbaddr", sbaddr_out, 32'h0000_0000);
    @(negedge clk);
    r_valid = 1'b0; autoinc = 1'b0;

    // Asynchronous reset mid-transfer
    @(negedge clk);
    sbaddr_in = 32'h0000_4000; rod = 1'b1; sbdata_rv = 1'b1;
    @(negedge clk);
    clear_strobes();
    #1 check("ar_req_before", {31'd0, req}, 32'd1);
    r_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("ar_req", {31'd0, req}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_dvalid", {31'd0, dvalid}, 32'd0);
    check("ar_evalid", {31'd0, evalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; r_valid = 1'b0; rod = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_sysbus_access.md
# dm_sysbus_access

System-bus access (SBA) engine of the RISC-V external debug module (spec 0.13). It turns debugger requests into single transfers on a simple req/gnt/r_valid bus master port. Requests arrive as address/data strobes from the debug CSR block, and the engine returns read data, the post-increment address, a busy flag and error codes. It sits between the debug CSR block and the system interconnect, next to the hart-memory block.

## Interface
- BusWidth, 32: data and address width; only 32 and 64 are legal. MaxSize = log2(BusWidth/8), i.e. 2 or 3.
- clk_i  in  1  clock; the only clock in the block.
- rst_ni  in  1  reset; asynchronous and active-low.
- dmactive_i  in  1  debug module active; low aborts any transfer.
- master_req_o  out  1  bus request, held until granted.
- master_add_o  out  BusWidth  byte address.
- master_we_o  out  1  write enable.
- master_wdata_o  out  BusWidth  lane-aligned write data.
- master_be_o  out  BusWidth/8  byte enables.
- master_gnt_i  in  1  grant; the request is accepted when req and gnt are both high.
- master_r_valid_i  in  1  response valid, for both reads and writes.
- master_r_rdata_i  in  BusWidth  read data.
- sbaddress_i  in  BusWidth  current sbaddress CSR value.
- sbaddress_o  out  BusWidth  next sbaddress value; the CSR block captures it every cycle while sbbusy_o is high.
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress0.
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1 each  sbcs control bits.
- sbaccess_i  in  3  access size, log2 bytes.
- sbdata_i  in  BusWidth  sbdata0 written value.
- sbdata_write_valid_i  in  1  debugger wrote sbdata0.
- sbdata_read_valid_i  in  1  debugger read sbdata0.
- sbdata_o  out  BusWidth  read result, right-aligned.
- sbdata_valid_o  out  1  one-cycle strobe qualifying sbdata_o.
- sbbusy_o  out  1  transfer in progress.
- sberror_valid_o  out  1  one-cycle strobe qualifying sberror_o.
- sberror_o  out  3  sberror code: 3 = alignment, 4 = unsupported size.

## Operation
- The FSM has five states: Idle, Read, Write, WaitRead, WaitWrite. sbbusy_o = (state != Idle).
- Idle start condition, first match wins:
  1. sbdata_read_valid_i & sbreadondata_i → read.
  2. sbdata_write_valid_i → write.
  3. sbaddress_write_valid_i & sbreadonaddr_i → read.
- Start checks, applied in Idle before leaving:
  - sbaccess_i > MaxSize: stay in Idle, pulse sberror_valid_o with code 4, no bus request.
  - Otherwise, sbaddress_i not aligned to (1<<sbaccess_i): stay in Idle, pulse code 3.
  - Otherwise go to Read or Write.
- Read/Write: master_req_o=1, master_we_o=1 in Write only. On master_gnt_i, go to WaitRead or WaitWrite.
- WaitRead: on master_r_valid_i, pulse sbdata_valid_o, return to Idle. sbdata_o = master_r_rdata_i >> (8·byte offset), with bits above the access size zeroed.
- WaitWrite: on master_r_valid_i, return to Idle.
- Address increment: in the completion cycle (r_valid in a Wait state) with sbautoincrement_i=1, sbaddress_o = sbaddress_i + (1<<sbaccess_i), modulo 2^BusWidth so it wraps. At all other times sbaddress_o = sbaddress_i.
- master_add_o = sbaddress_i.
- master_be_o = ((1<<(1<<sbaccess_i))−1) << byte offset, where byte offset = sbaddress_i[MaxSize−1:0].
- master_wdata_o = sbdata_i << (8·byte offset).
- dmactive_i low: next state is Idle from any state, with no strobes and no error. Any response that arrives later while in Idle is ignored.
- Start strobes that arrive while busy are ignored; busy-error reporting is the CSR block's job.

## Timing
- Reset state: Idle. master_req_o, master_we_o, sbbusy_o, sbdata_valid_o and sberror_valid_o are all 0, and sberror_o = 0.
- Combinational outputs during reset follow the rules above: master_add_o and sbaddress_o equal sbaddress_i, and sbdata_o equals the shifted and masked master_r_rdata_i.
- A start strobe in cycle N gives master_req_o in cycle N+1.
- A grant in the same cycle as the request moves the FSM to the Wait state at the next edge.
- A response can arrive at the earliest in the cycle after the grant. The strobes then fire combinationally in that cycle, and sbbusy_o drops in the following cycle.
- An error strobe is combinational in the start cycle; sbbusy_o never rises.
- Grant and r_valid in the same cycle while in Read/Write: the r_valid is ignored, because it belongs to the next state.

## Structure
- The shared dm package holds the sberror code enum (None=0, Timeout=1, BadAddr=2, Alignment=3, Size=4, Other=7) and the FSM state enum.
- One module, no sub-modules. The size/offset decode can be written as functions inside it.

## Test plan
- BusWidth=32, word read: sbaddress=0x1000, sbreadonaddr=1, address-write strobe, gnt on the first req cycle, r_valid with 0xDEADBEEF two cycles later → sbdata_valid_o pulses with sbdata_o=0xDEADBEEF; sbbusy_o high for 3 cycles.
- Byte write at 0x1003, sbdata=0x5A → be=4'b1000, wdata=0x5A000000, we=1. With sbautoincrement=1, sbaddress_o=0x1004 in the completion cycle.
- Halfword read at 0x1001 → sberror_valid_o pulses with code 3, no request issued. sbaccess=3 on BusWidth=32 → code 4.
- Grant withheld for 5 cycles → req stays high with stable address, be and wdata throughout.
- Drop dmactive_i while in WaitRead → Idle next cycle; a later r_valid produces no sbdata_valid_o.
- Autoincrement wrap: word access at 0xFFFFFFFC with sbautoincrement=1 → sbaddress_o=0x00000000. Async reset mid-transfer → all strobes and req deassert immediately.
